// File: rtl/breakout_pkg.sv
// rtl/breakout_pkg.sv - shared screen constants, ball defaults and edge-flag indices
// Also holds the stage-1 record carried between detector pipeline stages.
package breakout_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int BORDER_WIDTH = 8;

  localparam int BALL_SIZE_DEFAULT = 4;

  localparam int TOP    = 0;
  localparam int BOTTOM = 1;
  localparam int LEFT   = 2;
  localparam int RIGHT  = 3;

  typedef struct packed {
    logic       in_ball;
    logic [3:0] edges;
    logic       obstacle;
    logic       strobe;
  } stage1_t;

  // Last covered coordinate, widened so a window at the screen edge cannot wrap.
  function automatic logic [10:0] span_end(input logic [9:0] start, input int size);
    return {1'b0, start} + 11'(size - 1);
  endfunction

endpackage

// File: rtl/ball_hit_window.sv
// rtl/ball_hit_window.sv - square window range and edge compare against a pixel position
// Purely combinational; reused for ball collision and paddle hit-zone detection.
module ball_hit_window
  import breakout_pkg::*;
#(
  parameter int SIZE = BALL_SIZE_DEFAULT
) (
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_active,
  input  logic [9:0] win_x,
  input  logic [9:0] win_y,
  output logic       in_win,
  output logic [3:0] edges
);

  logic [10:0] x_end;
  logic [10:0] y_end;
  logic        in_x;
  logic        in_y;

  assign x_end = span_end(win_x, SIZE);
  assign y_end = span_end(win_y, SIZE);

  assign in_x   = (pix_x >= win_x) && ({1'b0, pix_x} <= x_end);
  assign in_y   = (pix_y >= win_y) && ({1'b0, pix_y} <= y_end);
  assign in_win = pix_active && in_x && in_y;

  always_comb begin
    edges         = '0;
    edges[TOP]    = (pix_y == win_y);
    edges[BOTTOM] = ({1'b0, pix_y} == y_end);
    edges[LEFT]   = (pix_x == win_x);
    edges[RIGHT]  = ({1'b0, pix_x} == x_end);
  end

endmodule

// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - ball/obstacle overlap detector with per-frame hit count
// Optional brick-hit coordinate capture enabled by COLLISION_BRICK_HIT_EN.
module collision_detector
  import breakout_pkg::*;
#(
  parameter int BALL_SIZE        = BALL_SIZE_DEFAULT,
  parameter int FRAME_PULSE_LINE = 481
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_active,
  input  logic       obstacle,
  input  logic [9:0] ball_x,
  input  logic [8:0] ball_y,
  output logic       frame_pulse,
  output logic       collision,
  output logic       ball_top_col,
  output logic       ball_bottom_col,
  output logic       ball_left_col,
  output logic       ball_right_col,
`ifdef COLLISION_BRICK_HIT_EN
  output logic [3:0] hit_count,
  input  logic       brick,
  output logic       brick_hit_valid,
  output logic [9:0] brick_hit_x,
  output logic [9:0] brick_hit_y
`else
  output logic [3:0] hit_count
`endif
);

  logic       frame_origin;
  logic [9:0] sx;
  logic [8:0] sy;
  logic [9:0] win_x;
  logic [9:0] win_y;
  logic       in_win;
  logic [3:0] edges;
  stage1_t    s1;
  logic       hit;
  logic [3:0] hit_cnt;

  assign frame_origin = (pix_x == '0) && (pix_y == '0);

  // The origin pixel already sees the freshly captured position, so the whole
  // frame is judged against one consistent ball location.
  assign win_x = frame_origin ? ball_x : sx;
  assign win_y = {1'b0, (frame_origin ? ball_y : sy)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx <= '0;
      sy <= '0;
    end else if (frame_origin) begin
      sx <= ball_x;
      sy <= ball_y;
    end
  end

  ball_hit_window #(
    .SIZE(BALL_SIZE)
  ) u_window (
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_active (pix_active),
    .win_x      (win_x),
    .win_y      (win_y),
    .in_win     (in_win),
    .edges      (edges)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.in_ball  <= in_win;
      s1.edges    <= edges;
      s1.obstacle <= obstacle;
      s1.strobe   <= (pix_x == '0) && (pix_y == 10'(FRAME_PULSE_LINE));
    end
  end

  assign hit = s1.in_ball & s1.obstacle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collision       <= 1'b0;
      ball_top_col    <= 1'b0;
      ball_bottom_col <= 1'b0;
      ball_left_col   <= 1'b0;
      ball_right_col  <= 1'b0;
      frame_pulse     <= 1'b0;
    end else begin
      collision       <= hit;
      ball_top_col    <= hit & s1.edges[TOP];
      ball_bottom_col <= hit & s1.edges[BOTTOM];
      ball_left_col   <= hit & s1.edges[LEFT];
      ball_right_col  <= hit & s1.edges[RIGHT];
      frame_pulse     <= s1.strobe;
    end
  end

  // A collision coinciding with frame_pulse belongs to the frame just starting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt   <= '0;
      hit_count <= '0;
    end else if (frame_pulse) begin
      hit_count <= hit_cnt;
      hit_cnt   <= {3'b000, collision};
    end else if (collision && (hit_cnt != 4'hF)) begin
      hit_cnt <= hit_cnt + 4'd1;
    end
  end

`ifdef COLLISION_BRICK_HIT_EN
  logic       s1_brick;
  logic [9:0] s1_x;
  logic [9:0] s1_y;
  logic       brick_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_brick <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_brick <= brick;
      s1_x     <= pix_x;
      s1_y     <= pix_y;
    end
  end

  assign brick_new = hit & s1_brick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brick_hit_valid <= 1'b0;
      brick_hit_x     <= '0;
      brick_hit_y     <= '0;
    end else if (brick_new && (!brick_hit_valid || frame_pulse)) begin
      brick_hit_valid <= 1'b1;
      brick_hit_x     <= s1_x;
      brick_hit_y     <= s1_y;
    end else if (frame_pulse) begin
      brick_hit_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_collision_detector.sv
// tb/tb_collision_detector.sv - scoreboard bench for collision_detector
// Brick-capture scenario is included when COLLISION_BRICK_HIT_EN is defined.
module tb_collision_detector;

  localparam int BS  = 4;
  localparam int FPL = 481;

  logic       clk;
  logic       rst;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       pix_active;
  logic       obstacle;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       frame_pulse;
  logic       collision;
  logic       ball_top_col;
  logic       ball_bottom_col;
  logic       ball_left_col;
  logic       ball_right_col;
  logic [3:0] hit_count;
  logic       brick_sel;
`ifdef COLLISION_BRICK_HIT_EN
  logic       brick;
  logic       brick_hit_valid;
  logic [9:0] brick_hit_x;
  logic [9:0] brick_hit_y;
`endif

  int         asserts;
  int         fails;
  logic [5:0] exp_q[$];
  logic [5:0] act_q[$];
  logic [5:0] m_prev;
  int         m_sx;
  int         m_sy;

  collision_detector #(
    .BALL_SIZE        (BS),
    .FRAME_PULSE_LINE (FPL)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pix_x           (pix_x),
    .pix_y           (pix_y),
    .pix_active      (pix_active),
    .obstacle        (obstacle),
    .ball_x          (ball_x),
    .ball_y          (ball_y),
    .frame_pulse     (frame_pulse),
    .collision       (collision),
    .ball_top_col    (ball_top_col),
    .ball_bottom_col (ball_bottom_col),
    .ball_left_col   (ball_left_col),
    .ball_right_col  (ball_right_col),
`ifdef COLLISION_BRICK_HIT_EN
    .hit_count       (hit_count),
    .brick           (brick),
    .brick_hit_valid (brick_hit_valid),
    .brick_hit_x     (brick_hit_x),
    .brick_hit_y     (brick_hit_y)
`else
    .hit_count       (hit_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one pixel; the expected output after this edge is the previous pixel's result.
  task automatic px(input int x, input int y, input bit act, input bit obs);
    bit in_b;
    bit c;
    pix_x      = 10'(x);
    pix_y      = 10'(y);
    pix_active = act;
    obstacle   = obs;
`ifdef COLLISION_BRICK_HIT_EN
    brick      = obs & brick_sel;
`endif
    if (x == 0 && y == 0) begin
      m_sx = int'(ball_x);
      m_sy = int'(ball_y);
    end
    in_b = act && (x >= m_sx) && (x <= m_sx + BS - 1) && (y >= m_sy) && (y <= m_sy + BS - 1);
    c    = in_b && obs;
    exp_q.push_back(m_prev);
    m_prev = {c, c && (y == m_sy), c && (y == m_sy + BS - 1), c && (x == m_sx),
              c && (x == m_sx + BS - 1), (x == 0) && (y == FPL)};
    @(posedge clk);
    #1;
    act_q.push_back({collision, ball_top_col, ball_bottom_col, ball_left_col,
                     ball_right_col, frame_pulse});
  endtask

  task automatic row(input int y, input int x0, input int x1, input int ox0, input int ox1);
    for (int x = x0; x <= x1; x++) px(x, y, y < 480, (x >= ox0) && (x <= ox1));
  endtask

  task automatic frame_start();
    px(0, 0, 1'b1, 1'b0);
  endtask

  task automatic frame_end();
    px(0, FPL, 1'b0, 1'b0);
    repeat (3) px(700, 600, 1'b0, 1'b0);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ball_x = '0;
    ball_y = '0;
    pix_x = 10'd700;
    pix_y = 10'd600;
    pix_active = 1'b0;
    obstacle = 1'b0;
    brick_sel = 1'b0;
`ifdef COLLISION_BRICK_HIT_EN
    brick = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    asserts++;
    if ({collision, ball_top_col, ball_bottom_col, ball_left_col, ball_right_col,
         frame_pulse, hit_count} !== 10'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0", {collision, ball_top_col,
               ball_bottom_col, ball_left_col, ball_right_col, frame_pulse, hit_count});
    end
    rst = 1'b0;
    m_prev = '0;
    m_sx = 0;
    m_sy = 0;
  endtask

  task automatic test_single_corner();
    logic [5:0] e, a;
    int n = 0;
    ball_x = 10'd100;
    ball_y = 9'd200;
    clear_sb();
    frame_start();
    for (int y = 199; y <= 204; y++) begin
      if (y == 200) row(y, 96, 108, 100, 100);
      else row(y, 96, 108, 1, 0);
    end
    frame_end();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      if (a[5]) n++;
      asserts++;
      if (a !== e) begin
        fails++;
        $display("FAIL corner_stream: got %b expected %b", a, e);
      end
    end
    asserts++;
    if (n !== 1) begin fails++; $display("FAIL corner_count: got %0d expected 1", n); end
    asserts++;
    if (hit_count !== 4'd1) begin
      fails++;
      $display("FAIL corner_hit_count: got %0d expected 1", hit_count);
    end
  endtask

  task automatic test_bottom_row();
    logic [5:0] e, a;
    int n = 0;
    clear_sb();
    frame_start();
    row(202, 90, 110, 1, 0);
    row(203, 0, 639, 0, 639);
    row(204, 90, 110, 1, 0);
    frame_end();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      if (a[5]) begin
        n++;
        asserts++;
        if (a[3] !== 1'b1) begin fails++; $display("FAIL bottom_flag: got %b expected 1", a[3]); end
      end
      asserts++;
      if (a !== e) begin
        fails++;
        $display("FAIL bottom_stream: got %b expected %b", a, e);
      end
    end
    asserts++;
    if (n !== 4) begin fails++; $display("FAIL bottom_count: got %0d expected 4", n); end
    asserts++;
    if (hit_count !== 4'd4) begin
      fails++;
      $display("FAIL bottom_hit_count: got %0d expected 4", hit_count);
    end
  endtask

  task automatic test_screen_corner();
    logic [5:0] e, a;
    int n = 0;
    ball_x = 10'd636;
    ball_y = 9'd476;
    clear_sb();
    frame_start();
    for (int y = 475; y <= 480; y++) row(y, 0, 639, 0, 639);
    frame_end();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      if (a[5]) n++;
      asserts++;
      if (a !== e) begin
        fails++;
        $display("FAIL wrap_stream: got %b expected %b", a, e);
      end
    end
    asserts++;
    if (n !== 16) begin fails++; $display("FAIL wrap_count: got %0d expected 16", n); end
    asserts++;
    if (hit_count !== 4'd15) begin
      fails++;
      $display("FAIL wrap_saturate: got %0d expected 15", hit_count);
    end
  endtask

  task automatic test_shadow();
    logic [5:0] e, a;
    int n = 0;
    ball_x = 10'd100;
    ball_y = 9'd200;
    clear_sb();
    frame_start();
    row(50, 0, 9, 1, 0);
    ball_x = 10'd300;
    for (int y = 200; y <= 203; y++) row(y, 90, 310, 0, 639);
    frame_end();
    frame_start();
    for (int y = 200; y <= 203; y++) row(y, 90, 310, 0, 639);
    frame_end();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      if (a[5]) n++;
      asserts++;
      if (a !== e) begin
        fails++;
        $display("FAIL shadow_stream: got %b expected %b", a, e);
      end
    end
    asserts++;
    if (n !== 32) begin fails++; $display("FAIL shadow_count: got %0d expected 32", n); end
  endtask

  task automatic test_reset_midframe();
    logic [5:0] e, a;
    int n_fp = 0;
    ball_x = 10'd100;
    ball_y = 9'd200;
    clear_sb();
    frame_start();
    row(200, 96, 108, 1, 0);
    row(201, 96, 101, 100, 103);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      asserts++;
      if (a !== e) begin
        fails++;
        $display("FAIL prerst_stream: got %b expected %b", a, e);
      end
    end
    asserts++;
    if (collision !== 1'b1) begin
      fails++;
      $display("FAIL prerst_collision: got %b expected 1", collision);
    end
    #2;
    rst = 1'b1;
    #1;
    asserts++;
    if ({collision, ball_top_col, ball_bottom_col, ball_left_col, ball_right_col,
         frame_pulse, hit_count} !== 10'd0) begin
      fails++;
      $display("FAIL async_reset: got %b required 0", {collision, ball_top_col,
               ball_bottom_col, ball_left_col, ball_right_col, frame_pulse, hit_count});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_prev = '0;
    m_sx = 0;
    m_sy = 0;
    row(201, 102, 107, 100, 103);
    for (int y = 202; y <= 480; y++) px(0, y, y < 480, 1'b0);
    frame_end();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      if (a[0]) n_fp++;
      asserts++;
      if (a !== e) begin
        fails++;
        $display("FAIL postrst_stream: got %b expected %b", a, e);
      end
    end
    asserts++;
    if (n_fp !== 1) begin fails++; $display("FAIL postrst_pulses: got %0d expected 1", n_fp); end
    asserts++;
    if (hit_count !== 4'd0) begin
      fails++;
      $display("FAIL postrst_hit_count: got %0d expected 0", hit_count);
    end
  endtask

`ifdef COLLISION_BRICK_HIT_EN
  task automatic test_brick_hit();
    logic [5:0] e, a;
    ball_x = 10'd100;
    ball_y = 9'd200;
    brick_sel = 1'b1;
    clear_sb();
    frame_start();
    asserts++;
    if (brick_hit_valid !== 1'b0) begin
      fails++;
      $display("FAIL brick_initial: got %b expected 0", brick_hit_valid);
    end
    row(201, 96, 108, 102, 103);
    row(202, 96, 108, 1, 0);
    asserts++;
    if ({brick_hit_valid, brick_hit_x, brick_hit_y} !== {1'b1, 10'd102, 10'd201}) begin
      fails++;
      $display("FAIL brick_capture: got v=%b x=%0d y=%0d expected v=1 x=102 y=201",
               brick_hit_valid, brick_hit_x, brick_hit_y);
    end
    brick_sel = 1'b0;
    frame_end();
    asserts++;
    if (brick_hit_valid !== 1'b0) begin
      fails++;
      $display("FAIL brick_clear: got %b expected 0", brick_hit_valid);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = act_q.pop_front();
      asserts++;
      if (a !== e) begin
        fails++;
        $display("FAIL brick_stream: got %b expected %b", a, e);
      end
    end
  endtask
`endif

  initial begin
    asserts = 0;
    fails = 0;
    test_reset();
    test_single_corner();
    test_bottom_row();
    test_screen_corner();
    test_shadow();
    test_reset_midframe();
`ifdef COLLISION_BRICK_HIT_EN
    test_brick_hit();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
